// File: rtl/demux_pkg.sv
// Shared constants and the select decoder for the 1:4 buffered demultiplexer.
// Imported by the top level so channel count and select width live in one place.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel first-word-fall-through FIFO; head word is read straight from
// registered storage so rd_data is valid whenever empty is low.
module chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is reset as well, so out_data reads zero after reset instead of stale words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (rst)
    count <= (AW+1)'(DEPTH));

endmodule

// File: rtl/demux1x4_buffered.sv
// Routes one input word to one of four buffered output channels; a stalled
// consumer only back-pressures traffic addressed to its own channel.
module demux1x4_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*WIDTH-1:0]  out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic              push;

  // Ready looks only at the target's current fullness: no push-through on a same-cycle pop.
  assign in_ready  = ~full[in_sel];
  assign push      = in_valid & in_ready;
  assign wr_en     = sel_to_onehot(in_sel) & {NUM_CH{push}};
  assign out_valid = ~empty;
  assign rd_en     = out_valid & out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data (in_data),
      .full    (full[i]),
      .rd_en   (rd_en[i]),
      .rd_data (out_data[i*WIDTH +: WIDTH]),
      .empty   (empty[i])
    );
  end

endmodule

// File: tb/tb_demux1x4_buffered.sv
// Directed bench for demux1x4_buffered: routing, back-pressure, same-cycle
// push/pop, wrap-around and asynchronous reset.
module tb_demux1x4_buffered;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;

  int errors = 0;
  int checks = 0;

  demux1x4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [1:0] sel, input logic [7:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready sel=%0d data=%h: in_ready=%b want 1", sel, d, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ready=%b want 0000/0/1", out_valid, out_data, in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b want 0000/1", out_valid, in_ready);
    end
  endtask

  task automatic test_routing();
    logic [3:0] exp_valid [4];
    exp_valid = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 8'hA0 + 8'(i);
      tick();
      checks++;
      if (out_valid !== exp_valid[i]) begin
        errors++;
        $display("FAIL route_valid step %0d: valid=%b want %b", i, out_valid, exp_valid[i]);
      end
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 32'hA3A2A1A0) begin
      errors++;
      $display("FAIL route_data: data=%h want a3a2a1a0", out_data);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL route_ready sel=%0d: in_ready=%b want 1", s, in_ready);
      end
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL route_drain: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 4'b0000;
    push_word(2'd1, 8'h11);
    push_word(2'd1, 8'h12);
    in_sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_ch1: in_ready=%b want 0", in_ready);
    end
    in_sel = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_ch0: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 8'h13;
    tick();
    checks++;
    if (out_data[15:8] !== 8'h11 || in_ready !== 1'b0 || out_valid !== 4'b0010) begin
      errors++;
      $display("FAIL full_hold: head=%h ready=%b valid=%b want 11/0/0010", out_data[15:8], in_ready, out_valid);
    end
    out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_no_passthru: in_ready=%b want 0", in_ready);
    end
    tick();
    out_ready = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[15:8] !== 8'h12) begin
      errors++;
      $display("FAIL full_after_pop: ready=%b head=%h want 1/12", in_ready, out_data[15:8]);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    tick();
    checks++;
    if (out_data[15:8] !== 8'h13 || out_valid !== 4'b0010) begin
      errors++;
      $display("FAIL full_order: head=%h valid=%b want 13/0010", out_data[15:8], out_valid);
    end
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL full_empty: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 4'b0000;
    push_word(2'd3, 8'h31);
    push_word(2'd3, 8'h32);
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 8'h33;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_ready: in_ready=%b want 0", in_ready);
    end
    tick();
    out_ready = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[31:24] !== 8'h32) begin
      errors++;
      $display("FAIL fullpop_next: ready=%b head=%h want 1/32", in_ready, out_data[31:24]);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_refull: in_ready=%b want 0", in_ready);
    end
    out_ready = 4'b1000;
    tick();
    checks++;
    if (out_data[31:24] !== 8'h33 || out_valid !== 4'b1000) begin
      errors++;
      $display("FAIL fullpop_order: head=%h valid=%b want 33/1000", out_data[31:24], out_valid);
    end
    tick();
    out_ready = 4'b0000;
  endtask

  task automatic test_simul();
    out_ready = 4'b0000;
    push_word(2'd0, 8'h55);
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h66;
    out_ready = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_data[7:0] !== 8'h55) begin
      errors++;
      $display("FAIL simul_pre: ready=%b head=%h want 1/55", in_ready, out_data[7:0]);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    checks++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h66 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_post: valid=%b head=%h ready=%b want 0001/66/1", out_valid, out_data[7:0], in_ready);
    end
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL simul_count1: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got2 [$];
    logic [7:0] got0 [$];
    int sent;
    int cyc;
    out_ready = 4'b0000;
    push_word(2'd0, 8'hC0);
    push_word(2'd0, 8'hC1);
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || out_valid != 4'b0000) && cyc < 300) begin
      out_ready = {1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1};
      in_valid  = (sent < 10);
      in_sel    = 2'd2;
      in_data   = 8'h20 + 8'(sent);
      #1;
      if (out_valid[2] && out_ready[2]) got2.push_back(out_data[23:16]);
      if (out_valid[0] && out_ready[0]) got0.push_back(out_data[7:0]);
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL wrap_timeout: sent=%0d drained=%0d want 10/10", sent, got2.size());
    end
    checks++;
    if (got2.size() != 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d words want 10", got2.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got2[k] !== 8'h20 + 8'(k)) begin
          errors++;
          $display("FAIL wrap_word %0d: got %h want %h", k, got2[k], 8'h20 + 8'(k));
        end
      end
    end
    checks++;
    if (got0.size() != 2 || got0[0] !== 8'hC0 || got0[1] !== 8'hC1) begin
      errors++;
      $display("FAIL wrap_ch0: got %0d words want c0,c1", got0.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 4'b0000;
    push_word(2'd2, 8'hE1);
    push_word(2'd2, 8'hE2);
    in_sel = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%h ready=%b want 0000/0/1", out_valid, out_data, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid[2] !== 1'b0 || out_data[23:16] !== 8'h00) begin
      errors++;
      $display("FAIL reset_ch2_empty: valid2=%b head=%h want 0/00", out_valid[2], out_data[23:16]);
    end
  endtask

  initial begin
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    test_reset();
    test_routing();
    test_full();
    test_full_pop();
    test_simul();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
